multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over the shared
//  PC/IR/ALU/regfile datapath and a single req/ready memory port. Drives fmt to the ALU decoder.
//  Stops on ECALL/EBREAK, illegal opcode, or memory timeout. Counts retired instructions.
// PARAMETERS
//  CNT_W       32  width of instret counter (wraps modulo 2^CNT_W)
//  MEM_TIMEOUT 0   max cycles mem_valid may wait for mem_ready before bus error; 0 = never
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  opcode       in   7      IR[6:0] (registered instruction)
//  branch_taken in   1      datapath comparator result for current B instr
//  mem_ready    in   1      memory accepted/completed current request
//  mem_valid    out  1      memory request
//  mem_we       out  1      store (valid only with mem_valid)
//  mem_addr_sel out  1      0=PC, 1=ALUOUT
//  ir_we        out  1      load IR from memory data; also latches OLDPC<=PC
//  pc_we        out  1      write PC
//  pc_src       out  2      0=PC+4, 1=ALUOUT (registered), 2=ALU result (comb)
//  alu_a_sel    out  2      0=rs1, 1=OLDPC
//  alu_b_sel    out  2      0=rs2, 1=IMM
//  fmt          out  4      format code to ALU decoder (package encoding)
//  rf_we        out  1      register file write
//  wb_sel       out  2      0=ALUOUT, 1=MDR, 2=PC (i.e. return addr), 3=IMM
//  halt         out  1      sticky stop flag
//  cause        out  2      0=none, 1=ecall/ebreak, 2=illegal opcode, 3=mem timeout
//  instret      out  CNT_W  retired instruction count
// BEHAVIOUR
//  Reset (async): state=FETCH, halt=0, cause=0, instret=0, timeout cnt=0; all strobes 0 while asserted.
//  fmt from opcode: 0110011 R=0, 0010011 I=1, 0000011 IL=2, 1110011 IE=3, 0100011 S=4,
//   1100011 B=5, 1101111 J=6, 1100111 JI=7, 0110111 U=8, 0010111 UP=9; other -> illegal.
//  Strobes are combinational from state (+mem_ready); default 0, selects 0.
//  FETCH: mem_valid=1, addr_sel=PC; on mem_ready: ir_we=1, pc_we=1 (PC+4) -> DECODE; else stay.
//  DECODE (1 cycle): a=OLDPC, b=IMM (branch/jal target into ALUOUT). Illegal -> HALT cause 2;
//   IE -> HALT cause 1 (counted as retired). Else -> EXEC.
//  EXEC: R: a=rs1,b=rs2 -> WB. I: a=rs1,b=IMM -> WB. IL/S: a=rs1,b=IMM -> MEM.
//   U: -> WB. UP: a=OLDPC,b=IMM -> WB.
//   B: a=rs1,b=rs2; if branch_taken pc_we=1,pc_src=1 -> FETCH.
//   J: rf_we=1,wb_sel=2, pc_we=1,pc_src=1 -> FETCH.
//   JI: a=rs1,b=IMM, rf_we=1,wb_sel=2, pc_we=1,pc_src=2 -> FETCH (rd==rs1 safe: rs1 read pre-write).
//  MEM: mem_valid=1, addr_sel=ALUOUT, mem_we=(S); on mem_ready: S -> FETCH, IL -> WB; else stay.
//  WB: rf_we=1; wb_sel = IL?1 : U?3 : 0 -> FETCH.
//  Latency w/ zero-wait memory: B/J/JI 3, R/I/U/UP/S 4, IL 5 cycles; +1 per memory wait cycle.
//  instret += 1 on each transition into FETCH from EXEC/MEM/WB and on IE entering HALT.
//  Timeout: counter clears on entering FETCH/MEM and on mem_ready; if MEM_TIMEOUT>0 and count
//   reaches MEM_TIMEOUT with mem_ready=0 -> HALT cause 3, mem_valid drops next cycle.
//  HALT: all strobes 0, halt=1, cause held; only reset exits. First cause wins.
//  mem_valid, once raised, stays high until mem_ready (or timeout / reset).
//  Reset mid-access drops mem_valid immediately; no partial writeback.
// STRUCTURE
//  Package riscv_ctrl_pkg: opcode constants, fmt codes (R..UP=0..9), state enum,
//   pc_src/wb_sel/alu_*_sel/cause encodings; shared with ALU decoder and datapath.
//  Sub-module opcode_fmt_dec: combinational opcode -> {fmt, illegal}. FSM + counters stay here.
// TESTING
//  ADD (0x002081B3), mem_ready=1 -> states F,D,E,WB; rf_we in cycle 4, wb_sel=0, instret 0->1.
//  LW (0x0000A103), mem_ready low 2 cycles in MEM -> mem_valid held 3 cycles, addr_sel=1, wb_sel=1, 7 cycles total.
//  BEQ taken vs not -> pc_we=1,pc_src=1 in cycle 3 only when branch_taken=1; both back to FETCH, instret+1.
//  JALR (0x000080E7) -> cycle 3: rf_we=1,wb_sel=2,pc_we=1,pc_src=2 simultaneously.
//  opcode 0x7F -> halt=1,cause=2 after DECODE, no later strobes; ECALL -> cause=1, instret+1.
//  MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> halt cause=3; async reset mid-MEM -> mem_valid=0 same cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller, the ALU decoder and
// the datapath: opcode constants, format codes, FSM states and the mux/cause
// encodings used on the controller outputs.
package riscv_ctrl_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_IL = 7'b0000011;
  localparam logic [6:0] OP_IE = 7'b1110011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JI = 7'b1100111;
  localparam logic [6:0] OP_U  = 7'b0110111;
  localparam logic [6:0] OP_UP = 7'b0010111;

  // Format code seen by the ALU decoder; FMT_NONE marks an unknown opcode
  typedef enum logic [3:0] {
    FMT_R    = 4'd0,
    FMT_I    = 4'd1,
    FMT_IL   = 4'd2,
    FMT_IE   = 4'd3,
    FMT_S    = 4'd4,
    FMT_B    = 4'd5,
    FMT_J    = 4'd6,
    FMT_JI   = 4'd7,
    FMT_U    = 4'd8,
    FMT_UP   = 4'd9,
    FMT_NONE = 4'd15
  } fmt_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;

  localparam logic [1:0] ASEL_RS1   = 2'd0;
  localparam logic [1:0] ASEL_OLDPC = 2'd1;
  localparam logic [1:0] BSEL_RS2   = 2'd0;
  localparam logic [1:0] BSEL_IMM   = 2'd1;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ENV     = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Single req/ready memory port between the controller (master) and memory
// (slave).
//  mem_valid     request outstanding
//  mem_we        store (meaningful only with mem_valid)
//  mem_addr_sel  0 = PC, 1 = ALUOUT
//  mem_ready     memory accepted/completed the current request
interface multicycle_ctrl_if;
  logic mem_valid;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_valid,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_opcode_fmt_dec.sv
// Combinational opcode -> format decoder.
//  opcode   in   7  IR[6:0]
//  fmt      out  4  format code (FMT_NONE when illegal)
//  illegal  out  1  opcode is not a supported RV32I major opcode
module opcode_fmt_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output fmt_e       fmt,
  output logic       illegal
);

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_R:    fmt = FMT_R;
      OP_I:    fmt = FMT_I;
      OP_IL:   fmt = FMT_IL;
      OP_IE:   fmt = FMT_IE;
      OP_S:    fmt = FMT_S;
      OP_B:    fmt = FMT_B;
      OP_J:    fmt = FMT_J;
      OP_JI:   fmt = FMT_JI;
      OP_U:    fmt = FMT_U;
      OP_UP:   fmt = FMT_UP;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM. Sequences fetch/decode/execute/memory/
// writeback over the shared datapath and one req/ready memory port, counts
// retired instructions and stops on ECALL/EBREAK, illegal opcode or memory
// timeout.
//  clk, reset     clock (rising edge), asynchronous active-high reset
//  mem            memory port (master side)
//  opcode         IR[6:0]
//  branch_taken   comparator result for the current branch
//  ir_we, pc_we   IR/OLDPC load, PC write
//  pc_src         0 PC+4, 1 ALUOUT, 2 ALU result
//  alu_a_sel/b    operand selects
//  fmt            format code to the ALU decoder
//  rf_we, wb_sel  register file write and source
//  halt, cause    sticky stop flag and its reason
//  instret        retired instruction count (wraps)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_FETCH  | request instruction at PC; on ready load IR, PC <= PC+4
// ST_DECODE | ALUOUT <= OLDPC+IMM; trap on illegal opcode or ECALL/EBREAK
// ST_EXEC   | ALU operation / branch / jump resolution
// ST_MEM    | data load/store at ALUOUT
// ST_WB     | register file write
// ST_HALT   | stopped; only reset leaves
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   mem,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_a_sel,
  output logic [1:0]          alu_b_sel,
  output logic [3:0]          fmt,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic                halt,
  output logic [1:0]          cause,
  output logic [CNT_W-1:0]    instret
);

  // Wait counter holds the number of wait cycles already spent; it only has
  // to reach MEM_TIMEOUT-1.
  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  fmt_e              fmt_c;
  logic              illegal_c;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instret_q;
  logic [TW-1:0]     tcnt_q;
  logic              retire;
  logic              mem_wait;
  logic              timeout_hit;

  logic       mv, mwe, mas, irwe, pcwe, rfwe;
  logic [1:0] pcs, asel, bsel, wbs;

  opcode_fmt_dec u_dec (
    .opcode  (opcode),
    .fmt     (fmt_c),
    .illegal (illegal_c)
  );

  assign timeout_hit = (MEM_TIMEOUT != 0) && (tcnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    retire   = 1'b0;
    mem_wait = 1'b0;
    mv       = 1'b0;
    mwe      = 1'b0;
    mas      = ADDR_PC;
    irwe     = 1'b0;
    pcwe     = 1'b0;
    pcs      = PC_SRC_PC4;
    asel     = ASEL_RS1;
    bsel     = BSEL_RS2;
    rfwe     = 1'b0;
    wbs      = WB_ALUOUT;

    case (state_q)
      ST_FETCH: begin
        mv = 1'b1;
        if (mem.mem_ready) begin
          irwe    = 1'b1;
          pcwe    = 1'b1;
          state_d = ST_DECODE;
        end else begin
          mem_wait = 1'b1;
          if (timeout_hit) begin
            state_d = ST_HALT;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end

      ST_DECODE: begin
        // Branch/jal target precomputed into ALUOUT
        asel = ASEL_OLDPC;
        bsel = BSEL_IMM;
        if (illegal_c) begin
          state_d = ST_HALT;
          cause_d = CAUSE_ILLEGAL;
        end else if (fmt_c == FMT_IE) begin
          state_d = ST_HALT;
          cause_d = CAUSE_ENV;
          retire  = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (fmt_c)
          FMT_R: state_d = ST_WB;
          FMT_I: begin
            bsel    = BSEL_IMM;
            state_d = ST_WB;
          end
          FMT_IL, FMT_S: begin
            bsel    = BSEL_IMM;
            state_d = ST_MEM;
          end
          FMT_U: state_d = ST_WB;
          FMT_UP: begin
            asel    = ASEL_OLDPC;
            bsel    = BSEL_IMM;
            state_d = ST_WB;
          end
          FMT_B: begin
            if (branch_taken) begin
              pcwe = 1'b1;
              pcs  = PC_SRC_ALUOUT;
            end
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          FMT_J: begin
            rfwe    = 1'b1;
            wbs     = WB_PC;
            pcwe    = 1'b1;
            pcs     = PC_SRC_ALUOUT;
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          FMT_JI: begin
            // rs1 is read before the rd write lands, so rd == rs1 is safe
            bsel    = BSEL_IMM;
            rfwe    = 1'b1;
            wbs     = WB_PC;
            pcwe    = 1'b1;
            pcs     = PC_SRC_ALU;
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        mv  = 1'b1;
        mas = ADDR_ALUOUT;
        mwe = (fmt_c == FMT_S);
        if (mem.mem_ready) begin
          if (fmt_c == FMT_S) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          mem_wait = 1'b1;
          if (timeout_hit) begin
            state_d = ST_HALT;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end

      ST_WB: begin
        rfwe = 1'b1;
        if (fmt_c == FMT_IL)     wbs = WB_MDR;
        else if (fmt_c == FMT_U) wbs = WB_IMM;
        else                     wbs = WB_ALUOUT;
        state_d = ST_FETCH;
        retire  = 1'b1;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      // Clears whenever the access completes or the state changes
      if (mem_wait && (state_d == state_q)) tcnt_q <= tcnt_q + TW'(1);
      else                                  tcnt_q <= '0;
    end
  end

  // Strobes are forced low while reset is held so an in-flight access drops
  // in the same cycle.
  assign mem.mem_valid    = mv & ~reset;
  assign mem.mem_we       = mwe & ~reset;
  assign mem.mem_addr_sel = mas & ~reset;
  assign ir_we            = irwe & ~reset;
  assign pc_we            = pcwe & ~reset;
  assign rf_we            = rfwe & ~reset;
  assign pc_src           = reset ? 2'd0 : pcs;
  assign alu_a_sel        = reset ? 2'd0 : asel;
  assign alu_b_sel        = reset ? 2'd0 : bsel;
  assign wb_sel           = reset ? 2'd0 : wbs;

  assign fmt     = fmt_c;
  assign halt    = (state_q == ST_HALT);
  assign cause   = cause_q;
  assign instret = instret_q;

endmodule
